pixel_frame_loader: RTL

PIXEL_FRAME_LOADER -- requirements
Module: pixel_frame_loader

---
 rtl/mlp_pkg.sv | 23 ++
 rtl/pixel_shift_packer.sv | 42 ++++
 rtl/pixel_frame_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP digit-classifier front end.
//   DATA_WIDTH  : bits per pixel
//   VECTOR_SIZE : pixels per frame (14x14)
//   loader_state_e : state encoding of the pixel frame loader
//   cnt_width() : width of a counter that must reach n inclusive
package mlp_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int VECTOR_SIZE = 196;

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        RESULT    = 2'd3
    } loader_state_e;

    // Bits needed to hold the values 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pixel_shift_packer.sv
// Serial-to-parallel pixel packer.
// Writes one pixel per enabled cycle into the slot selected by wr_idx;
// slot 0 occupies the most significant bits of vec.
//   clk     : rising-edge clock
//   reset   : synchronous active-low reset, clears the whole vector
//   wr_en   : write strobe (already qualified by the clock enable)
//   wr_idx  : pixel slot index, 0-based
//   wr_data : pixel value
//   vec     : packed frame, registered
module pixel_shift_packer
    import mlp_pkg::*;
#(
    parameter int DATA_WIDTH  = mlp_pkg::DATA_WIDTH,
    parameter int VECTOR_SIZE = mlp_pkg::VECTOR_SIZE,
    parameter int IDX_W       = mlp_pkg::cnt_width(VECTOR_SIZE)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wr_en,
    input  logic [IDX_W-1:0]                  wr_idx,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    output logic [DATA_WIDTH*VECTOR_SIZE-1:0] vec
);

    logic [DATA_WIDTH*VECTOR_SIZE-1:0] vec_r;

    // Frame storage: decode the slot index and write the addressed pixel.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vec_r <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < VECTOR_SIZE; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    vec_r[DATA_WIDTH*(VECTOR_SIZE-i)-1 -: DATA_WIDTH] <= wr_data;
                end
            end
        end
    end

    assign vec = vec_r;

endmodule

// File: rtl/pixel_frame_loader.sv
// Pixel frame loader: collects a streamed frame, hands it to the classifier
// with a one-cycle start pulse, then holds the classifier's digit until the
// consumer takes it.
//   clk, reset   : rising-edge clock, synchronous active-low reset
//   en           : clock enable; when low every register holds
//   pix_data/pix_valid/pix_last/pix_ready : pixel stream handshake
//   pixels_out   : packed frame, pixel 0 in the MSBs
//   start        : one-cycle classifier start pulse
//   cls_done/cls_digit : classifier completion and predicted digit
//   result_digit/result_valid/result_ready : result handshake
//   frame_err    : one-cycle pulse when pix_last disagrees with the count
// All outputs are registered.
module pixel_frame_loader
    import mlp_pkg::*;
#(
    parameter int DATA_WIDTH  = mlp_pkg::DATA_WIDTH,
    parameter int VECTOR_SIZE = mlp_pkg::VECTOR_SIZE
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              en,
    input  logic [DATA_WIDTH-1:0]             pix_data,
    input  logic                              pix_valid,
    input  logic                              pix_last,
    output logic                              pix_ready,
    output logic [DATA_WIDTH*VECTOR_SIZE-1:0] pixels_out,
    output logic                              start,
    input  logic                              cls_done,
    input  logic [3:0]                        cls_digit,
    output logic [3:0]                        result_digit,
    output logic                              result_valid,
    input  logic                              result_ready,
    output logic                              frame_err
);

    localparam int               CNT_W    = mlp_pkg::cnt_width(VECTOR_SIZE);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VECTOR_SIZE - 1);

    loader_state_e    state_r;
    loader_state_e    state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    logic             pix_ready_r;
    logic             start_r;
    logic             result_valid_r;
    logic             frame_err_r;
    logic [3:0]       result_digit_r;

    logic             pix_ready_nxt_s;
    logic             start_nxt_s;
    logic             result_valid_nxt_s;
    logic             frame_err_nxt_s;
    logic [3:0]       result_digit_nxt_s;

    logic             xfer_s;
    logic             last_idx_s;
    logic             good_end_s;
    logic             bad_end_s;

    // Transfer qualification and frame-boundary decode. The ready register
    // stays low for the first cycle after reset even though state is LOAD.
    always_comb begin
        xfer_s     = en && pix_valid && pix_ready_r && (state_r == LOAD);
        last_idx_s = (cnt_r == LAST_IDX);
        good_end_s = xfer_s && last_idx_s && pix_last;
        bad_end_s  = xfer_s && (last_idx_s != pix_last);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= LOAD;
        end else if (en) begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic. The START cycle never looks at cls_done, so a done
    // coinciding with the start pulse is ignored.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LOAD: begin
                if (good_end_s) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            START: begin
                state_nxt_s = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (cls_done) begin
                    state_nxt_s = RESULT;
                end else begin
                    state_nxt_s = WAIT_DONE;
                end
            end
            RESULT: begin
                if (result_ready) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = RESULT;
                end
            end
            default: begin
                state_nxt_s = LOAD;
            end
        endcase
    end

    // Output and counter next values, decoded from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        pix_ready_nxt_s    = (state_nxt_s == LOAD);
        start_nxt_s        = (state_nxt_s == START);
        result_valid_nxt_s = (state_nxt_s == RESULT);
        frame_err_nxt_s    = bad_end_s;
        result_digit_nxt_s = result_digit_r;
        cnt_nxt_s          = cnt_r;
        if ((state_r == WAIT_DONE) && cls_done) begin
            result_digit_nxt_s = cls_digit;
        end else begin
            result_digit_nxt_s = result_digit_r;
        end
        if (good_end_s || bad_end_s) begin
            cnt_nxt_s = '0;
        end else if (xfer_s) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Output and pixel-counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r          <= '0;
            pix_ready_r    <= 1'b0;
            start_r        <= 1'b0;
            result_valid_r <= 1'b0;
            frame_err_r    <= 1'b0;
            result_digit_r <= 4'd0;
        end else if (en) begin
            cnt_r          <= cnt_nxt_s;
            pix_ready_r    <= pix_ready_nxt_s;
            start_r        <= start_nxt_s;
            result_valid_r <= result_valid_nxt_s;
            frame_err_r    <= frame_err_nxt_s;
            result_digit_r <= result_digit_nxt_s;
        end
    end

    // Writes only happen in LOAD, so the frame is frozen from START until
    // the loader returns to LOAD.
    pixel_shift_packer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .VECTOR_SIZE (VECTOR_SIZE),
        .IDX_W       (CNT_W)
    ) u_packer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (xfer_s),
        .wr_idx  (cnt_r),
        .wr_data (pix_data),
        .vec     (pixels_out)
    );

    assign pix_ready    = pix_ready_r;
    assign start        = start_r;
    assign result_valid = result_valid_r;
    assign result_digit = result_digit_r;
    assign frame_err    = frame_err_r;

endmodule
